// File: rtl/sync_gen.sv
// Video timing generator: free-running x/y raster counters with registered, aligned hs/vs/border.
// Optional frame status outputs (frame_start, frame_cnt) are built when SYNC_GEN_FRAME_STATUS_EN is defined.
module sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic        fbclk,
  input  logic        fbclk_rst_b,
  output logic        hs,
  output logic        vs,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        border
`ifdef SYNC_GEN_FRAME_STATUS_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 13-bit constants so every decode compare is width-matched against {1'b0, counter}.
  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT_W   = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT_W   = 13'(V_ACTIVE);
  localparam logic [12:0] HS_BEG_W  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END_W  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG_W  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END_W  = 13'(V_ACTIVE + V_FP + V_SYNC);

  if ((H_TOTAL > 4096) || (V_TOTAL > 4096) || (H_ACTIVE == 0) || (V_ACTIVE == 0) ||
      ((H_ACTIVE % 2) != 0)) begin : g_cfg_err
    $error("sync_gen: illegal timing parameters");
  end

  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        border_q, border_d;
  logic        x_wrap_s;
  logic        y_wrap_s;

  // Next raster position and the decode of that position, so outputs land aligned with x/y.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    x_wrap_s = (x_q == H_LAST);
    y_wrap_s = (y_q == V_LAST);
    if (x_wrap_s) begin
      x_d = 12'd0;
      if (y_wrap_s) begin
        y_d = 12'd0;
      end else begin
        y_d = y_q + 12'd1;
      end
    end else begin
      x_d = x_q + 12'd1;
      y_d = y_q;
    end

    border_d = ~(({1'b0, x_d} < H_ACT_W) && ({1'b0, y_d} < V_ACT_W));

    if (({1'b0, x_d} >= HS_BEG_W) && ({1'b0, x_d} < HS_END_W)) begin
      hs_d = HS_POL;
    end else begin
      hs_d = ~HS_POL;
    end

    // vs covers whole lines, horizontal blanking included.
    if (({1'b0, y_d} >= VS_BEG_W) && ({1'b0, y_d} < VS_END_W)) begin
      vs_d = VS_POL;
    end else begin
      vs_d = ~VS_POL;
    end
  end

  // Raster counters and registered timing outputs; reset parks on pixel (0,0) with syncs inactive.
  always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
    if (!fbclk_rst_b) begin
      x_q      <= 12'd0;
      y_q      <= 12'd0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      border_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      border_q <= border_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign hs     = hs_q;
  assign vs     = vs_q;
  assign border = border_q;

`ifdef SYNC_GEN_FRAME_STATUS_EN
  logic        frame_wrap_s;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Frame marker follows the (0,0) decode; the counter steps only on a real wrap, not on reset.
  always_comb begin
    frame_wrap_s  = x_wrap_s & y_wrap_s;
    frame_start_d = frame_wrap_s;
    if (frame_wrap_s) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame status registers; (0,0) is presented during reset, so frame_start resets high.
  always_ff @(posedge fbclk or negedge fbclk_rst_b) begin
    if (!fbclk_rst_b) begin
      frame_start_q <= 1'b1;
      frame_cnt_q   <= 16'd0;
    end else begin
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sync_gen.sv
// Self-checking bench for sync_gen: three parameter sets, a cycle-index reference model,
// a boundary vector table, randomized reset pulses and frame-cadence sequences.
module tb_sync_gen;

  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    bit hp; bit vp;
  } cfg_t;

  typedef struct packed {
    int x; int y; bit b; bit h; bit v; bit fs; int fc;
  } exp_t;

  typedef struct {
    int t; int inst; int x; int y; bit b; bit h; bit v;
  } vec_t;

  logic        clk;
  logic        rst_b;
  logic        hs_a [3];
  logic        vs_a [3];
  logic        bd_a [3];
  logic [11:0] x_a  [3];
  logic [11:0] y_a  [3];
  logic        fs_a [3];
  logic [15:0] fc_a [3];

  cfg_t cfg [3];
  int   t;
  bit   mon_en;
  int   pass_cnt;
  int   total_cnt;

  sync_gen u_def (
    .fbclk(clk), .fbclk_rst_b(rst_b), .hs(hs_a[0]), .vs(vs_a[0]),
    .x(x_a[0]), .y(y_a[0]), .border(bd_a[0])
`ifdef SYNC_GEN_FRAME_STATUS_EN
    , .frame_start(fs_a[0]), .frame_cnt(fc_a[0])
`endif
  );

  sync_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_med (
    .fbclk(clk), .fbclk_rst_b(rst_b), .hs(hs_a[1]), .vs(vs_a[1]),
    .x(x_a[1]), .y(y_a[1]), .border(bd_a[1])
`ifdef SYNC_GEN_FRAME_STATUS_EN
    , .frame_start(fs_a[1]), .frame_cnt(fc_a[1])
`endif
  );

  sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
             .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
             .HS_POL(1'b1), .VS_POL(1'b1)) u_small (
    .fbclk(clk), .fbclk_rst_b(rst_b), .hs(hs_a[2]), .vs(vs_a[2]),
    .x(x_a[2]), .y(y_a[2]), .border(bd_a[2])
`ifdef SYNC_GEN_FRAME_STATUS_EN
    , .frame_start(fs_a[2]), .frame_cnt(fc_a[2])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycles elapsed since the last reset release (0 while reset is held).
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) t <= 0;
    else        t <= t + 1;
  end

  task automatic chk(input string name, input int inst, input int act, input int exp_v);
    total_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s[%0d] at t=%0d: got %0d, expected %0d", name, inst, t, act, exp_v);
  endtask

  // Reference: position is just the cycle index folded into the raster.
  function automatic exp_t model(input cfg_t c, input int tt);
    exp_t e;
    int ht, vt, col, row;
    ht   = c.ha + c.hf + c.hsw + c.hb;
    vt   = c.va + c.vf + c.vsw + c.vb;
    col  = tt % ht;
    row  = (tt / ht) % vt;
    e.x  = col;
    e.y  = row;
    e.b  = !((col < c.ha) && (row < c.va));
    e.h  = ((col >= c.ha + c.hf) && (col < c.ha + c.hf + c.hsw)) ? c.hp : !c.hp;
    e.v  = ((row >= c.va + c.vf) && (row < c.va + c.vf + c.vsw)) ? c.vp : !c.vp;
    e.fs = ((tt % (ht * vt)) == 0);
    e.fc = (tt / (ht * vt)) % 65536;
    return e;
  endfunction

  // Continuous scoreboard against the model on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        e = model(cfg[i], t);
        chk("mon_x", i, int'(x_a[i]), e.x);
        chk("mon_y", i, int'(y_a[i]), e.y);
        chk("mon_border", i, int'(bd_a[i]), int'(e.b));
        chk("mon_hs", i, int'(hs_a[i]), int'(e.h));
        chk("mon_vs", i, int'(vs_a[i]), int'(e.v));
`ifdef SYNC_GEN_FRAME_STATUS_EN
        chk("mon_frame_start", i, int'(fs_a[i]), int'(e.fs));
        chk("mon_frame_cnt", i, int'(fc_a[i]), e.fc);
`endif
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_x"}, i, int'(x_a[i]), 0);
      chk({tag, "_y"}, i, int'(y_a[i]), 0);
      chk({tag, "_border"}, i, int'(bd_a[i]), 0);
      chk({tag, "_hs"}, i, int'(hs_a[i]), int'(!cfg[i].hp));
      chk({tag, "_vs"}, i, int'(vs_a[i]), int'(!cfg[i].vp));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_b = 1'b0;
    @(negedge clk);
    #2 rst_b = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    int cur, last1, nfr1, bad1, b01, vsl1, run1, max1;
    int last2, nfr2, bad2, b02, hsh2, hsx2, vsx2;

    cfg[0] = cfg_t'{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = cfg_t'{640, 16, 96, 48, 4, 2, 2, 2, 1'b0, 1'b0};
    cfg[2] = cfg_t'{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1};

    // {t, instance, x, y, border, hs, vs}, sorted by t
    tbl.push_back(vec_t'{7, 2, 7, 0, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8, 2, 8, 0, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{10, 2, 10, 0, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{11, 2, 11, 0, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{12, 2, 12, 0, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{13, 2, 13, 0, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{14, 2, 0, 1, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{70, 2, 0, 5, 1'b1, 1'b0, 1'b1});
    tbl.push_back(vec_t'{83, 2, 13, 5, 1'b1, 1'b0, 1'b1});
    tbl.push_back(vec_t'{84, 2, 0, 6, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{97, 2, 13, 6, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{98, 2, 0, 0, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{639, 0, 639, 0, 1'b0, 1'b1, 1'b1});
    tbl.push_back(vec_t'{640, 0, 640, 0, 1'b1, 1'b1, 1'b1});
    tbl.push_back(vec_t'{655, 0, 655, 0, 1'b1, 1'b1, 1'b1});
    tbl.push_back(vec_t'{656, 0, 656, 0, 1'b1, 1'b0, 1'b1});
    tbl.push_back(vec_t'{751, 0, 751, 0, 1'b1, 1'b0, 1'b1});
    tbl.push_back(vec_t'{752, 0, 752, 0, 1'b1, 1'b1, 1'b1});
    tbl.push_back(vec_t'{799, 0, 799, 0, 1'b1, 1'b1, 1'b1});
    tbl.push_back(vec_t'{800, 0, 0, 1, 1'b0, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3199, 1, 799, 3, 1'b1, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3200, 1, 0, 4, 1'b1, 1'b1, 1'b1});
    tbl.push_back(vec_t'{4800, 1, 0, 6, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{5500, 1, 700, 6, 1'b1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{6399, 1, 799, 7, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{6400, 1, 0, 8, 1'b1, 1'b1, 1'b1});
    tbl.push_back(vec_t'{7999, 1, 799, 9, 1'b1, 1'b1, 1'b1});
    tbl.push_back(vec_t'{8000, 1, 0, 0, 1'b0, 1'b1, 1'b1});

    pass_cnt  = 0;
    total_cnt = 0;
    mon_en    = 1'b0;
    rst_b     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    mon_en = 1'b1;

    // Boundary table: one release, then walk forward to each listed cycle index.
    do_reset();
    #1;
    cur = 0;
    foreach (tbl[k]) begin
      repeat (tbl[k].t - cur) @(posedge clk);
      if (tbl[k].t != cur) #1;
      cur = tbl[k].t;
      chk("tbl_x", tbl[k].inst, int'(x_a[tbl[k].inst]), tbl[k].x);
      chk("tbl_y", tbl[k].inst, int'(y_a[tbl[k].inst]), tbl[k].y);
      chk("tbl_border", tbl[k].inst, int'(bd_a[tbl[k].inst]), int'(tbl[k].b));
      chk("tbl_hs", tbl[k].inst, int'(hs_a[tbl[k].inst]), int'(tbl[k].h));
      chk("tbl_vs", tbl[k].inst, int'(vs_a[tbl[k].inst]), int'(tbl[k].v));
    end

    // Asynchronous reset mid-line, then the first released edge advances to x = 1.
    do_reset();
    repeat (1100) @(posedge clk);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    #2 rst_b = 1'b1;
    #1 check_reset_vals("release");
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("first_edge_x", i, int'(x_a[i]), 1);

    // Randomized reset pulses at random phases; the scoreboard checks every cycle.
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(30, 2500)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3)) rst_b = 1'b0;
      #1 check_reset_vals("rand_rst");
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #($urandom_range(1, 3)) rst_b = 1'b1;
    end

    // Frame cadence over three frames of the medium raster (800x10) and the small one (14x7).
    do_reset();
    last1 = -1; nfr1 = 0; bad1 = 0; b01 = 0; vsl1 = 0; run1 = 0; max1 = 0;
    last2 = -1; nfr2 = 0; bad2 = 0; b02 = 0; hsh2 = 0; hsx2 = 0; vsx2 = 0;
    for (int c = 0; c <= 24000; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      if ((x_a[1] == 12'd0) && (y_a[1] == 12'd0)) begin
        if ((last1 >= 0) && (c - last1 != 8000)) bad1++;
        last1 = c;
        nfr1++;
      end
      if (c < 24000) begin
        if (!bd_a[1]) b01++;
        if (!vs_a[1]) begin
          vsl1++;
          run1++;
          if (run1 > max1) max1 = run1;
        end else begin
          run1 = 0;
        end
      end
      if ((x_a[2] == 12'd0) && (y_a[2] == 12'd0)) begin
        if ((last2 >= 0) && (c - last2 != 98)) bad2++;
        last2 = c;
        nfr2++;
      end
      if (c < 98 * 244) begin
        if (!bd_a[2]) b02++;
        if (hs_a[2]) hsh2++;
        if (hs_a[2] && (x_a[2] != 12'd10) && (x_a[2] != 12'd11)) hsx2++;
        if (vs_a[2] && (y_a[2] != 12'd5)) vsx2++;
      end
    end
    chk("med_frame_starts", 1, nfr1, 4);
    chk("med_bad_periods", 1, bad1, 0);
    chk("med_visible_cycles", 1, b01, 3 * 640 * 4);
    chk("med_vs_low_cycles", 1, vsl1, 3 * 1600);
    chk("med_vs_low_run", 1, max1, 1600);
    chk("small_frame_starts", 2, nfr2, 245);
    chk("small_bad_periods", 2, bad2, 0);
    chk("small_visible_cycles", 2, b02, 244 * 32);
    chk("small_hs_high_cycles", 2, hsh2, 244 * 7 * 2);
    chk("small_hs_stray", 2, hsx2, 0);
    chk("small_vs_stray", 2, vsx2, 0);
`ifdef SYNC_GEN_FRAME_STATUS_EN
    chk("med_frame_cnt_3", 1, int'(fc_a[1]), 3);
    chk("med_frame_start_wrap", 1, int'(fs_a[1]), 1);
    chk("small_frame_cnt", 2, int'(fc_a[2]), 244);
`endif

    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
